// File: rtl/de_coder_init_seq_if.sv
// Handshake between the power-up sequencer and the decoder I2C config block.
// The sequencer drives sub-address, data and a write pulse; the config block reports ready and NACK.
interface de_coder_init_seq_if;
    logic [7:0] SuBAddrL;
    logic [7:0] Data;
    logic       write;
    logic       ready;
    logic       errory;

    modport master (
        output SuBAddrL,
        output Data,
        output write,
        input  ready,
        input  errory
    );

    modport slave (
        input  SuBAddrL,
        input  Data,
        input  write,
        output ready,
        output errory
    );
endinterface

// File: rtl/de_coder_init_seq.sv
// Power-up sequencer for the video decoder: walks a {sub-address, data} table and issues
// each pair as one config-block write, with per-entry retry, busy timeout and settle gap.
module de_coder_init_seq #(
    parameter int NUM_REGS  = 38,
    parameter int AW        = 6,
    parameter int MAX_RETRY = 3,
    parameter int GAP_CYC   = 16,
    parameter int BUSY_TO   = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic [AW-1:0]               tbl_addr,
    input  logic [15:0]                 tbl_entry,
    de_coder_init_seq_if.master         cfg,
    output logic                        busy,
    output logic                        done,
    output logic                        fail,
    output logic [AW-1:0]               fail_idx,
    output logic [7:0]                  retry_cnt
);
    localparam int ATT_W = $clog2(MAX_RETRY + 2);
    localparam int TO_W  = $clog2(BUSY_TO + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [AW-1:0]    LAST_IDX = AW'(NUM_REGS - 1);
    localparam logic [ATT_W-1:0] ATT_LIM  = ATT_W'(MAX_RETRY);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TO - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP,
        S_DONE,
        S_FAIL
    } state_t;

    state_t            r_state,      w_state_next;
    logic [AW-1:0]     r_tbl_addr,   w_tbl_addr_next;
    logic [7:0]        r_sub,        w_sub_next;
    logic [7:0]        r_data,       w_data_next;
    logic              r_write,      w_write_next;
    logic              r_busy,       w_busy_next;
    logic              r_done,       w_done_next;
    logic              r_fail,       w_fail_next;
    logic [AW-1:0]     r_fail_idx,   w_fail_idx_next;
    logic [7:0]        r_retry_cnt,  w_retry_cnt_next;
    logic [ATT_W-1:0]  r_attempt,    w_attempt_next;
    logic [TO_W-1:0]   r_to_cnt,     w_to_cnt_next;
    logic [GAP_W-1:0]  r_gap_cnt,    w_gap_cnt_next;
    logic              r_retry_pend, w_retry_pend_next;
    logic              w_attempt_fail;

    // A busy timeout and a NACK are the same outcome: one failed attempt.
    assign w_attempt_fail = ((r_state == S_WAIT_BUSY) && cfg.ready && (r_to_cnt == TO_LAST)) ||
                            ((r_state == S_WAIT_DONE) && cfg.ready && cfg.errory);

    always_comb begin
        w_state_next      = r_state;
        w_tbl_addr_next   = r_tbl_addr;
        w_sub_next        = r_sub;
        w_data_next       = r_data;
        w_write_next      = 1'b0;
        w_busy_next       = r_busy;
        w_done_next       = r_done;
        w_fail_next       = r_fail;
        w_fail_idx_next   = r_fail_idx;
        w_retry_cnt_next  = r_retry_cnt;
        w_attempt_next    = r_attempt;
        w_to_cnt_next     = r_to_cnt;
        w_gap_cnt_next    = r_gap_cnt;
        w_retry_pend_next = r_retry_pend;

        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    w_state_next     = S_FETCH;
                    w_tbl_addr_next  = '0;
                    w_retry_cnt_next = '0;
                    w_done_next      = 1'b0;
                    w_fail_next      = 1'b0;
                    w_busy_next      = 1'b1;
                end
            end
            S_FETCH: begin
                w_sub_next     = tbl_entry[15:8];
                w_data_next    = tbl_entry[7:0];
                w_attempt_next = '0;
                w_state_next   = S_ISSUE;
            end
            S_ISSUE: begin
                if (cfg.ready) begin
                    w_write_next   = 1'b1;
                    w_to_cnt_next  = '0;
                    w_attempt_next = r_attempt + 1'b1;
                    w_state_next   = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!cfg.ready) begin
                    w_state_next = S_WAIT_DONE;
                end else if (r_to_cnt != TO_LAST) begin
                    w_to_cnt_next = r_to_cnt + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (cfg.ready && !cfg.errory) begin
                    w_retry_pend_next = 1'b0;
                    w_gap_cnt_next    = '0;
                    w_state_next      = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    if (r_retry_pend) begin
                        w_state_next = S_ISSUE;
                    end else if (r_tbl_addr == LAST_IDX) begin
                        w_state_next = S_DONE;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                    end else begin
                        w_tbl_addr_next = r_tbl_addr + 1'b1;
                        w_state_next    = S_FETCH;
                    end
                end else begin
                    w_gap_cnt_next = r_gap_cnt + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // Attempt counter counts issued writes, so attempts 1..MAX_RETRY may still retry.
        if (w_attempt_fail) begin
            if (r_attempt <= ATT_LIM) begin
                w_retry_cnt_next  = (r_retry_cnt == 8'hFF) ? r_retry_cnt : r_retry_cnt + 8'd1;
                w_retry_pend_next = 1'b1;
                w_gap_cnt_next    = '0;
                w_state_next      = S_GAP;
            end else begin
                w_state_next    = S_FAIL;
                w_busy_next     = 1'b0;
                w_fail_next     = 1'b1;
                w_fail_idx_next = r_tbl_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_tbl_addr   <= '0;
            r_sub        <= '0;
            r_data       <= '0;
            r_write      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_fail_idx   <= '0;
            r_retry_cnt  <= '0;
            r_attempt    <= '0;
            r_to_cnt     <= '0;
            r_gap_cnt    <= '0;
            r_retry_pend <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_tbl_addr   <= w_tbl_addr_next;
            r_sub        <= w_sub_next;
            r_data       <= w_data_next;
            r_write      <= w_write_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_fail       <= w_fail_next;
            r_fail_idx   <= w_fail_idx_next;
            r_retry_cnt  <= w_retry_cnt_next;
            r_attempt    <= w_attempt_next;
            r_to_cnt     <= w_to_cnt_next;
            r_gap_cnt    <= w_gap_cnt_next;
            r_retry_pend <= w_retry_pend_next;
        end
    end

    assign tbl_addr     = r_tbl_addr;
    assign cfg.SuBAddrL = r_sub;
    assign cfg.Data     = r_data;
    assign cfg.write    = r_write;
    assign busy         = r_busy;
    assign done         = r_done;
    assign fail         = r_fail;
    assign fail_idx     = r_fail_idx;
    assign retry_cnt    = r_retry_cnt;
endmodule

// File: tb/tb_de_coder_init_seq.sv
// Bench for de_coder_init_seq: a reference model predicts every write and the final status,
// a responder plays the config block and a monitor scores each write pulse.
module tb_de_coder_init_seq;
    localparam int NREG      = 4;
    localparam int AW        = 6;
    localparam int MAX_RETRY = 3;
    localparam int GAP_CYC   = 16;
    localparam int BUSY_TO   = 64;

    typedef struct {
        int         idx;
        logic [7:0] sub;
        logic [7:0] data;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] tbl_addr;
    logic [15:0]   tbl_entry;
    logic          busy, done, fail;
    logic [AW-1:0] fail_idx;
    logic [7:0]    retry_cnt;

    de_coder_init_seq_if cfg ();

    de_coder_init_seq #(
        .NUM_REGS (NREG),
        .AW       (AW),
        .MAX_RETRY(MAX_RETRY),
        .GAP_CYC  (GAP_CYC),
        .BUSY_TO  (BUSY_TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .tbl_addr (tbl_addr),
        .tbl_entry(tbl_entry),
        .cfg      (cfg.master),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .fail_idx (fail_idx),
        .retry_cnt(retry_cnt)
    );

    logic [15:0] tbl [0:63];
    assign tbl_entry = tbl[tbl_addr];

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   resp_q[$];
    int   plan_nack [0:NREG-1];
    bit   no_resp   = 0;
    bit   hold_low  = 0;
    int   busy_len  = 30;
    int   writes_seen  = 0;
    int   reset_events = 0;
    bit   mon_first = 1;
    int   exp_retry;
    bit   exp_fail;
    int   exp_idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, expv);
        end
    endtask

    task automatic chk_range(input string nm, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s got=%0d expected %0d..%0d", nm, got, lo, hi);
        end
    endtask

    // Reference model: expand the per-entry NACK plan into the ordered list of writes.
    task automatic build_model();
        int   att, used;
        bit   ok, dead, nack;
        exp_t x;
        exp_q.delete();
        resp_q.delete();
        exp_retry = 0;
        exp_fail  = 0;
        exp_idx   = 0;
        dead      = 0;
        for (int e = 0; e < NREG && !dead; e++) begin
            att  = 0;
            used = 0;
            ok   = 0;
            while (!ok && !dead) begin
                x.idx  = e;
                x.sub  = tbl[e][15:8];
                x.data = tbl[e][7:0];
                exp_q.push_back(x);
                att++;
                nack = no_resp || (used < plan_nack[e]);
                if (!no_resp) resp_q.push_back(nack);
                used++;
                if (!nack) ok = 1;
                else if (att <= MAX_RETRY) begin
                    if (exp_retry < 255) exp_retry++;
                end else begin
                    dead     = 1;
                    exp_fail = 1;
                    exp_idx  = e;
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_writes(input int target);
        int n = 0;
        while (writes_seen < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("write_arrival", (writes_seen >= target), 1);
    endtask

    task automatic run(input string nm, input int hold_cyc, input bit poke);
        int n, w0;
        build_model();
        mon_first = 1;
        hold_low  = (hold_cyc > 0);
        w0        = writes_seen;
        pulse_start();
        @(negedge clk);
        chk({nm, "_busy_after_start"}, busy, 1);
        chk({nm, "_done_cleared"}, done, 0);
        chk({nm, "_fail_cleared"}, fail, 0);
        if (hold_cyc > 0) begin
            repeat (hold_cyc) @(negedge clk);
            chk({nm, "_no_write_while_held"}, writes_seen - w0, 0);
            hold_low = 0;
        end
        if (poke) begin
            wait_writes(w0 + 2);
            pulse_start();
        end
        n = 0;
        while (!(done || fail) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_finished"}, (done || fail), 1);
        repeat (40) @(negedge clk);
        chk({nm, "_done"}, done, !exp_fail);
        chk({nm, "_fail"}, fail, exp_fail);
        chk({nm, "_busy_end"}, busy, 0);
        chk({nm, "_retry_cnt"}, retry_cnt, exp_retry);
        if (exp_fail) chk({nm, "_fail_idx"}, fail_idx, exp_idx);
        chk({nm, "_pending_writes"}, exp_q.size(), 0);
        resp_q.delete();
    endtask

    // Config-block model: latches a write at the clock edge, goes busy, then reports ACK/NACK.
    initial begin : responder
        logic       pend;
        logic [7:0] s_sub, s_data;
        int         mark;
        bit         nk;
        cfg.ready  = 1'b1;
        cfg.errory = 1'b0;
        forever begin
            @(negedge clk);
            pend   = cfg.write && !no_resp;
            s_sub  = cfg.SuBAddrL;
            s_data = cfg.Data;
            @(posedge clk); #1;
            if (pend) begin
                nk = 1'b0;
                if (resp_q.size() > 0) nk = resp_q.pop_front();
                mark       = reset_events;
                cfg.ready  = 1'b0;
                cfg.errory = 1'b0;
                repeat (busy_len - 1) @(posedge clk);
                #1;
                if (mark == reset_events) begin
                    chk("sub_stable", cfg.SuBAddrL, s_sub);
                    chk("data_stable", cfg.Data, s_data);
                end
                cfg.errory = nk;
                cfg.ready  = 1'b1;
            end else begin
                cfg.ready = !hold_low;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        int   idle_cnt;
        idle_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                idle_cnt = 0;
            end else if (cfg.write) begin
                writes_seen++;
                chk("write_needs_ready", cfg.ready, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write idx=%0d sub=%02h data=%02h expected no write",
                             tbl_addr, cfg.SuBAddrL, cfg.Data);
                end else begin
                    e = exp_q.pop_front();
                    $display("write idx=%0d sub=%02h data=%02h (model idx=%0d sub=%02h data=%02h)",
                             tbl_addr, cfg.SuBAddrL, cfg.Data, e.idx, e.sub, e.data);
                    chk("write_idx", tbl_addr, e.idx);
                    chk("write_sub", cfg.SuBAddrL, e.sub);
                    chk("write_data", cfg.Data, e.data);
                end
                if (!mon_first) begin
                    if (no_resp) chk_range("timeout_spacing", idle_cnt, BUSY_TO + GAP_CYC - 1, BUSY_TO + GAP_CYC + 4);
                    else         chk_range("gap_spacing", idle_cnt, GAP_CYC, GAP_CYC + 4);
                end
                mon_first = 0;
                idle_cnt  = 0;
            end else if (cfg.ready) begin
                idle_cnt++;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w0, n;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 64; i++) tbl[i] = 16'($urandom);
        for (int i = 0; i < NREG; i++) plan_nack[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_write", cfg.write, 0);
        chk("rst_tbl_addr", tbl_addr, 0);
        chk("rst_sub", cfg.SuBAddrL, 0);
        chk("rst_data", cfg.Data, 0);
        chk("rst_retry_cnt", retry_cnt, 0);
        chk("rst_fail_idx", fail_idx, 0);
        @(posedge clk); #1 reset = 1'b0;

        run("ideal", 0, 0);

        plan_nack[2] = 1;
        run("nack_once", 0, 0);

        plan_nack[2] = 0;
        plan_nack[1] = 99;
        run("nack_always", 0, 0);

        plan_nack[1] = 0;
        no_resp = 1;
        run("no_response", 0, 0);
        no_resp = 0;

        run("ready_held", 100, 0);

        // Reset while entry 1 is in flight; the config block finishes on its own.
        build_model();
        mon_first = 1;
        w0 = writes_seen;
        pulse_start();
        wait_writes(w0 + 2);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        reset_events++;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_fail", fail, 0);
        chk("midrst_write", cfg.write, 0);
        chk("midrst_tbl_addr", tbl_addr, 0);
        chk("midrst_sub", cfg.SuBAddrL, 0);
        chk("midrst_data", cfg.Data, 0);
        chk("midrst_retry_cnt", retry_cnt, 0);
        exp_q.delete();
        n = 0;
        while (!cfg.ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        resp_q.delete();
        run("after_reset", 0, 0);

        run("start_while_busy", 0, 1);
        run("restart_from_done", 0, 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 64; i++) tbl[i] = 16'($urandom);
            for (int i = 0; i < NREG; i++) plan_nack[i] = int'($urandom_range(0, 4));
            busy_len = int'($urandom_range(3, 40));
            run($sformatf("random%0d", r), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
